// File: rtl/priority_encoder.sv
// 4-to-2 priority encoder with registered outputs.
// Reports the index of the highest-numbered active request among D3..D0
// together with a valid flag, one clock after the inputs are sampled.
module priority_encoder (
    input  logic clk,
    input  logic rst,
    input  logic D3,
    input  logic D2,
    input  logic D1,
    input  logic D0,
    output logic Y1,
    output logic Y0,
    output logic V
);

    // Encoded index and valid flag, registered once (stage p0).
    logic [1:0] idx_p0;
    logic       vld_p0;

    // Highest active request wins; an all-zero vector yields index 0 with
    // valid low, so consumers must qualify the index with the valid flag.
    function automatic logic [2:0] encode(input logic [3:0] req);
        logic [2:0] res;
        res = 3'b000;
        if (req[3])      res = 3'b111;
        else if (req[2]) res = 3'b101;
        else if (req[1]) res = 3'b011;
        else if (req[0]) res = 3'b001;
        return res;
    endfunction

    // Sample the request lines each edge; reset clears index and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_p0 <= 2'b00;
            vld_p0 <= 1'b0;
        end else begin
            {idx_p0, vld_p0} <= encode({D3, D2, D1, D0});
        end
    end

    assign Y1 = idx_p0[1];
    assign Y0 = idx_p0[0];
    assign V  = vld_p0;

endmodule

// File: tb/tb_priority_encoder.sv
// Directed testbench for the registered 4-to-2 priority encoder.
module tb_priority_encoder;

    logic clk;
    logic rst;
    logic D3, D2, D1, D0;
    logic Y1, Y0, V;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       rst;
        logic [3:0] d;
        logic [1:0] y;
        logic       v;
    } vec_t;

    vec_t vecs[$];

    priority_encoder dut (
        .clk(clk),
        .rst(rst),
        .D3 (D3),
        .D2 (D2),
        .D1 (D1),
        .D0 (D0),
        .Y1 (Y1),
        .Y0 (Y0),
        .V  (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] ey, input logic ev);
        tests_run++;
        if ({Y1, Y0} !== ey || V !== ev) begin
            tests_failed++;
            $display("FAIL %s: got Y=%b%b V=%b, expected Y=%b V=%b",
                     name, Y1, Y0, V, ey, ev);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] d);
        rst = r;
        {D3, D2, D1, D0} = d;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        drive(1'b1, 4'b1111);

        //           rst   D3..D0   Y      V
        vecs.push_back('{1'b1, 4'b1111, 2'b00, 1'b0});
        vecs.push_back('{1'b1, 4'b1111, 2'b00, 1'b0});
        vecs.push_back('{1'b0, 4'b1111, 2'b11, 1'b1});
        vecs.push_back('{1'b0, 4'b0001, 2'b00, 1'b1});
        vecs.push_back('{1'b0, 4'b0010, 2'b01, 1'b1});
        vecs.push_back('{1'b0, 4'b0100, 2'b10, 1'b1});
        vecs.push_back('{1'b0, 4'b1000, 2'b11, 1'b1});
        vecs.push_back('{1'b0, 4'b1011, 2'b11, 1'b1});
        vecs.push_back('{1'b0, 4'b0111, 2'b10, 1'b1});
        vecs.push_back('{1'b0, 4'b0011, 2'b01, 1'b1});
        vecs.push_back('{1'b0, 4'b0000, 2'b00, 1'b0});
        vecs.push_back('{1'b0, 4'b0001, 2'b00, 1'b1});
        vecs.push_back('{1'b0, 4'b0000, 2'b00, 1'b0});
        vecs.push_back('{1'b0, 4'b0101, 2'b10, 1'b1});
        vecs.push_back('{1'b0, 4'b1110, 2'b11, 1'b1});
        vecs.push_back('{1'b0, 4'b0110, 2'b10, 1'b1});
        vecs.push_back('{1'b0, 4'b1000, 2'b11, 1'b1});
        vecs.push_back('{1'b1, 4'b1000, 2'b00, 1'b0});
        vecs.push_back('{1'b0, 4'b1000, 2'b11, 1'b1});

        // Each vector is applied mid-cycle and checked just after the edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].d);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_d%b_rst%b", i, vecs[i].d, vecs[i].rst),
                  vecs[i].y, vecs[i].v);
        end

        // Hold: changing D between edges must not move the outputs.
        #1;
        drive(1'b0, 4'b0001);
        #2;
        check("hold_before_edge", 2'b11, 1'b1);
        @(posedge clk);
        #1;
        check("hold_after_edge", 2'b00, 1'b1);

        // Reset is synchronous: raising it between edges changes nothing yet.
        @(negedge clk);
        drive(1'b0, 4'b0100);
        @(posedge clk);
        #1;
        check("pre_sync_rst", 2'b10, 1'b1);
        drive(1'b1, 4'b0100);
        #2;
        check("sync_rst_no_async", 2'b10, 1'b1);
        @(posedge clk);
        #1;
        check("sync_rst_applied", 2'b00, 1'b0);

        // Back-to-back distinct vectors with no gap, each one cycle later.
        @(negedge clk);
        drive(1'b0, 4'b0010);
        @(negedge clk);
        check("b2b_first", 2'b01, 1'b1);
        drive(1'b0, 4'b1001);
        @(negedge clk);
        check("b2b_second", 2'b11, 1'b1);
        drive(1'b0, 4'b0000);
        @(negedge clk);
        check("b2b_third", 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/priority_encoder.md
Name: priority_encoder

Overview:
- 4-to-2 priority encoder with registered outputs.
- Reports the index of the highest-numbered active request line among D3..D0, plus a valid flag.
- Used as a small arbitration/selection primitive: downstream logic reads Y1/Y0 when V is high.
- Single clock domain; the outputs are flops, and the inputs feed them directly.

Parameters:
- None. The width is fixed at 4 request inputs and a 2-bit encoded output.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- D3   input  1  request line 3 (highest priority)
- D2   input  1  request line 2
- D1   input  1  request line 1
- D0   input  1  request line 0 (lowest priority)
- Y1   output 1  encoded index, MSB (registered)
- Y0   output 1  encoded index, LSB (registered)
- V    output 1  valid: at least one request was active in the sampled inputs (registered)

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- All outputs are flops clocked on the rising edge of clk. There is no combinational path from inputs to outputs.
- Reset:
  - If rst=1 at a rising edge, Y1=0, Y0=0, V=0 after that edge.
  - Reset has priority over all input activity.
  - Asserting rst mid-stream clears the outputs on the next edge. Previously sampled requests are lost, and no request is retained.
- Normal operation (rst=0): each rising edge samples D3..D0 and loads {Y1,Y0,V} per this priority order (first match wins):
  - D3=1 -> Y=11, V=1 (D2..D0 ignored)
  - else D2=1 -> Y=10, V=1
  - else D1=1 -> Y=01, V=1
  - else D0=1 -> Y=00, V=1
  - else (all zero) -> Y=00, V=0
- Latency: exactly 1 clock from input sample to output. Outputs hold their value between edges.
- Throughput: a new input vector can be accepted every cycle. There is no handshake and no stall.
- Y=00 is ambiguous between "D0 only" and "none active"; V alone distinguishes the two. Consumers must qualify Y with V.
- Multiple simultaneous requests are legal; only the highest index is reported.
- Inputs are synchronous to clk, and the block performs no synchronisation.
- No X-propagation handling is required beyond standard RTL semantics. After reset, the outputs are always defined.
- Power-up before the first reset: output values are unspecified. Verification starts checking only after rst has been asserted for at least one edge.

Test Plan:
- Reset: rst=1 for 2 edges with D=1111 -> Y1Y0=00, V=0. Then release rst with D=1111 -> next edge Y=11, V=1.
- One-hot sweep: D3..D0 = 0001, 0010, 0100, 1000 on successive edges -> outputs one cycle later Y=00, 01, 10, 11, each with V=1.
- Priority with multiple actives: D=1011 -> Y=11, V=1. D=0111 -> Y=10, V=1. D=0011 -> Y=01, V=1.
- No request: D=0000 -> Y=00, V=0, distinguished from D=0001 (Y=00, V=1) by V only.
- Latency/hold: change D between edges -> outputs unchanged until the next rising edge. Back-to-back distinct vectors each appear exactly one cycle later.
- Mid-stream reset: D=1000 streaming, assert rst for one edge -> Y=00, V=0 on that edge. Deassert -> Y=11, V=1 on the following edge.
